// File: rtl/concat_pkg.sv
// Shared constants, state encoding and output formatting for the field concatenation sequencer.
package concat_pkg;
  localparam int FIELD_W    = 2;
  localparam int NUM_FIELDS = 5;
  localparam int REP        = 3;
  localparam int WORD_W     = FIELD_W * NUM_FIELDS;
  localparam int OUT_W      = REP * WORD_W;
  localparam int CNT_W      = $clog2(NUM_FIELDS + 1);

  localparam logic MODE_CONCAT = 1'b0;
  localparam logic MODE_REP    = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } seq_state_t;

  function automatic logic [OUT_W-1:0] format_word(input logic mode,
                                                   input logic [WORD_W-1:0] word);
    format_word = (mode == MODE_REP) ? {REP{word}} : OUT_W'(word);
  endfunction
endpackage

// File: rtl/field_shift_reg.sv
// Left-shifting field accumulator: newest field enters the LSBs, so the first field ends up MSB.
// Clear beats load beats shift; NUM_FIELDS must be at least 2.
module field_shift_reg #(
  parameter int FIELD_W    = 2,
  parameter int NUM_FIELDS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          load,
  input  logic                          shift,
  input  logic [FIELD_W-1:0]            din,
  output logic [FIELD_W*NUM_FIELDS-1:0] q
);
  localparam int W = FIELD_W * NUM_FIELDS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= W'(din);
    end else if (shift) begin
      q <= {q[W-FIELD_W-1:0], din};
    end
  end
endmodule

// File: rtl/concat_field_sequencer.sv
// Collects NUM_FIELDS fields MSB-first and presents the word (or its replication) one cycle after the last field.
// Fields are refused while a word is held; the word holds until out_ready_i, with a one-cycle bubble after the handshake.
module concat_field_sequencer
  import concat_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_i,
  input  logic               fld_valid_i,
  input  logic [FIELD_W-1:0] fld_data_i,
  output logic               fld_ready_o,
  input  logic               abort_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OUT_W-1:0]   out_word_o,
  output logic               out_mode_o,
  output logic [CNT_W-1:0]   fld_cnt_o
);
  seq_state_t          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mode_q;
  logic                out_valid_q;
  logic [OUT_W-1:0]    out_word_q;
  logic [WORD_W-1:0]   sr_q;
  logic                accept;
  logic                last;
  logic [WORD_W-1:0]   word_nxt;

  assign fld_ready_o = (state_q != HOLD);
  assign accept      = fld_valid_i & fld_ready_o;
  assign last        = accept && (state_q == COLLECT) && (cnt_q == CNT_W'(NUM_FIELDS - 1));
  // Final word is formatted from the incoming field directly so it can be registered on the last accept.
  assign word_nxt    = {sr_q[WORD_W-FIELD_W-1:0], fld_data_i};

  field_shift_reg #(
    .FIELD_W   (FIELD_W),
    .NUM_FIELDS(NUM_FIELDS)
  ) u_sr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (abort_i),
    .load (accept && (state_q == IDLE)),
    .shift(accept && (state_q == COLLECT)),
    .din  (fld_data_i),
    .q    (sr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_CONCAT;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else if (abort_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_CONCAT;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q  <= mode_i;
            cnt_q   <= CNT_W'(1);
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_word_q  <= format_word(mode_q, word_nxt);
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_word_o  = out_word_q;
  assign out_mode_o  = mode_q;
  assign fld_cnt_o   = cnt_q;
endmodule

// File: tb/tb_concat_field_sequencer.sv
// Directed bench for concat_field_sequencer: concat, replicate, backpressure, gaps, abort and async reset.
module tb_concat_field_sequencer;
  import concat_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               mode_i;
  logic               fld_valid_i;
  logic [FIELD_W-1:0] fld_data_i;
  logic               fld_ready_o;
  logic               abort_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [OUT_W-1:0]   out_word_o;
  logic               out_mode_o;
  logic [CNT_W-1:0]   fld_cnt_o;

  int nvec = 0;
  int nerr = 0;

  concat_field_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_i     (mode_i),
    .fld_valid_i(fld_valid_i),
    .fld_data_i (fld_data_i),
    .fld_ready_o(fld_ready_o),
    .abort_i    (abort_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_word_o (out_word_o),
    .out_mode_o (out_mode_o),
    .fld_cnt_o  (fld_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fld(input logic v, input logic [FIELD_W-1:0] d, input logic m);
    fld_valid_i = v;
    fld_data_i  = d;
    mode_i      = m;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    mode_i      = 1'b0;
    fld_valid_i = 1'b0;
    fld_data_i  = '0;
    abort_i     = 1'b0;
    out_ready_i = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_word",  32'(out_word_o),  32'h0);
    chk("rst_mode",  32'(out_mode_o),  32'h0);
    chk("rst_cnt",   32'(fld_cnt_o),   32'h0);
    #11 rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(fld_ready_o), 32'h1);

    // Concat: 1,2,3,0,1 -> 0x1B1
    out_ready_i = 1'b1;
    fld(1, 2'd1, 0);
    chk("cat_cnt1", 32'(fld_cnt_o), 32'd1);
    fld(1, 2'd2, 0);
    fld(1, 2'd3, 0);
    fld(1, 2'd0, 0);
    chk("cat_cnt4", 32'(fld_cnt_o), 32'd4);
    chk("cat_novalid", 32'(out_valid_o), 32'h0);
    fld(1, 2'd1, 0);
    chk("cat_valid", 32'(out_valid_o), 32'h1);
    chk("cat_word",  32'(out_word_o),  32'h00001B1);
    chk("cat_mode",  32'(out_mode_o),  32'h0);
    chk("cat_cnt5",  32'(fld_cnt_o),   32'd5);
    chk("cat_rdy0",  32'(fld_ready_o), 32'h0);
    fld(0, 2'd0, 0);
    chk("cat_done_valid", 32'(out_valid_o), 32'h0);
    chk("cat_done_cnt",   32'(fld_cnt_o),   32'd0);
    chk("cat_done_rdy",   32'(fld_ready_o), 32'h1);

    // Replicate: mode only sampled on first field
    fld(1, 2'd1, 1);
    fld(1, 2'd2, 0);
    fld(1, 2'd3, 0);
    fld(1, 2'd0, 0);
    fld(1, 2'd1, 0);
    chk("rep_valid", 32'(out_valid_o), 32'h1);
    chk("rep_word",  32'(out_word_o),  32'h1B16C5B1);
    chk("rep_mode",  32'(out_mode_o),  32'h1);
    fld(0, 2'd0, 0);
    chk("rep_done_valid", 32'(out_valid_o), 32'h0);

    // Backpressure: 2,1,0,3,2 -> 0x24E held while out_ready_i low
    out_ready_i = 1'b0;
    fld(1, 2'd2, 0);
    fld(1, 2'd1, 0);
    fld(1, 2'd0, 0);
    fld(1, 2'd3, 0);
    fld(1, 2'd2, 0);
    fld_data_i = 2'd1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 32'(out_valid_o), 32'h1);
      chk("bp_word",  32'(out_word_o),  32'h000024E);
      chk("bp_rdy",   32'(fld_ready_o), 32'h0);
      chk("bp_cnt",   32'(fld_cnt_o),   32'd5);
      tick();
    end
    out_ready_i = 1'b1;
    fld(0, 2'd0, 0);
    chk("bp_hs_valid", 32'(out_valid_o), 32'h0);
    chk("bp_hs_cnt",   32'(fld_cnt_o),   32'd0);
    fld(0, 2'd0, 0);
    chk("bp_after_valid", 32'(out_valid_o), 32'h0);

    // Gapped input: 3,_,3,_,_,3,3,3 -> 0x3FF; gap data must be ignored
    fld(1, 2'd3, 0);
    chk("gap_c1", 32'(fld_cnt_o), 32'd1);
    fld(0, 2'd1, 0);
    chk("gap_c1b", 32'(fld_cnt_o), 32'd1);
    fld(1, 2'd3, 0);
    chk("gap_c2", 32'(fld_cnt_o), 32'd2);
    fld(0, 2'd1, 0);
    fld(0, 2'd0, 0);
    chk("gap_c2b", 32'(fld_cnt_o), 32'd2);
    fld(1, 2'd3, 0);
    chk("gap_c3", 32'(fld_cnt_o), 32'd3);
    fld(1, 2'd3, 0);
    chk("gap_c4", 32'(fld_cnt_o), 32'd4);
    fld(1, 2'd3, 0);
    chk("gap_c5",    32'(fld_cnt_o),   32'd5);
    chk("gap_valid", 32'(out_valid_o), 32'h1);
    chk("gap_word",  32'(out_word_o),  32'h00003FF);
    fld(0, 2'd0, 0);
    chk("gap_done", 32'(out_valid_o), 32'h0);

    // Abort mid-word with a simultaneous field: field dropped
    fld(1, 2'd1, 0);
    fld(1, 2'd1, 0);
    fld(1, 2'd1, 0);
    chk("ab_cnt3", 32'(fld_cnt_o), 32'd3);
    abort_i = 1'b1;
    fld(1, 2'd3, 0);
    abort_i = 1'b0;
    chk("ab_cnt0",  32'(fld_cnt_o),   32'd0);
    chk("ab_valid", 32'(out_valid_o), 32'h0);
    chk("ab_rdy",   32'(fld_ready_o), 32'h1);
    for (int i = 0; i < 5; i++) fld(1, 2'd2, 0);
    chk("ab2_valid", 32'(out_valid_o), 32'h1);
    chk("ab2_word",  32'(out_word_o),  32'h00002AA);
    fld(0, 2'd0, 0);
    chk("ab2_done", 32'(out_valid_o), 32'h0);

    // Async reset mid-COLLECT; out_word_o still holds 0x2AA beforehand
    fld(1, 2'd1, 0);
    fld(1, 2'd2, 0);
    fld_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt",   32'(fld_cnt_o),   32'd0);
    chk("arst_word",  32'(out_word_o),  32'h0);
    chk("arst_valid", 32'(out_valid_o), 32'h0);
    #10 rst_n = 1'b1;
    tick();
    chk("arst_rdy", 32'(fld_ready_o), 32'h1);
    fld(1, 2'd3, 1);
    fld(1, 2'd2, 0);
    fld(1, 2'd1, 0);
    fld(1, 2'd0, 0);
    fld(1, 2'd3, 0);
    chk("arst_word2", 32'(out_word_o),  32'h393E4F93);
    chk("arst_mode2", 32'(out_mode_o),  32'h1);
    fld(0, 2'd0, 0);
    chk("arst_done", 32'(out_valid_o), 32'h0);

    // Abort in HOLD together with out_ready_i: word is not delivered
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) fld(1, 2'd1, 0);
    chk("abh_valid", 32'(out_valid_o), 32'h1);
    chk("abh_word",  32'(out_word_o),  32'h0000155);
    fld_valid_i = 1'b0;
    out_ready_i = 1'b1;
    abort_i     = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abh_valid0", 32'(out_valid_o), 32'h0);
    chk("abh_word0",  32'(out_word_o),  32'h0);
    chk("abh_cnt0",   32'(fld_cnt_o),   32'd0);
    tick();
    chk("abh_stay0", 32'(out_valid_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/concat_field_sequencer.md
Name: concat_field_sequencer

Overview:
- Sequencing controller for the 2-bit-field concatenation/replication datapath.
- Collects NUM_FIELDS 2-bit fields one at a time over a valid/ready handshake.
- Assembles them MSB-first into a 10-bit word. Presents either the zero-extended word or its 3x replication on a 30-bit output under a valid/ready handshake.
- Sits between a serial field source and downstream logic that consumes packed words.

Parameters:
- FIELD_W, 2, width of one input field.
- NUM_FIELDS, 5, fields per word; word width WORD_W = FIELD_W*NUM_FIELDS (10).
- REP, 3, replication factor; output width OUT_W = REP*WORD_W (30).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode_i  input  1  0 = concat, 1 = replicate; sampled only on the first field of a word.
- fld_valid_i  input  1  field source has data.
- fld_data_i  input  FIELD_W  field value.
- fld_ready_o  output  1  sequencer accepts a field this cycle.
- abort_i  input  1  synchronous discard of the word in progress.
- out_valid_o  output  1  assembled word available.
- out_ready_i  input  1  consumer accepts word.
- out_word_o  output  OUT_W  assembled output.
- out_mode_o  output  1  mode latched for the presented word.
- fld_cnt_o  output  3  fields accepted so far in the current word (0..NUM_FIELDS).

Behaviour:
- Reset (rst_n low, async): state=IDLE, fld_cnt_o=0, out_valid_o=0, out_word_o=0, out_mode_o=0, internal shift register=0, fld_ready_o=1 once reset releases.
- FSM states IDLE, COLLECT, HOLD.
- Field accept = fld_valid_i & fld_ready_o. fld_ready_o=1 in IDLE and COLLECT, 0 in HOLD (combinational from state).
  - fld_data_i is ignored when there is no accept.
- Field order: the first accepted field is most significant. word = {f0,f1,f2,f3,f4}, implemented as shift-left by FIELD_W with the new field in the LSBs.
- IDLE:
  - On accept: latch mode_i, store field, cnt=1, go to COLLECT.
  - With no accept: stay in IDLE.
- COLLECT:
  - Each accept shifts in and increments cnt. mode_i is ignored.
  - Gaps in fld_valid_i hold the state.
  - On the accept that makes cnt=NUM_FIELDS: go to HOLD.
- HOLD:
  - out_valid_o=1 from the clock edge after the final accept (latency 1 cycle).
  - out_word_o = {20'b0, word} if latched mode=0, {word,word,word} if mode=1.
  - out_word_o and out_mode_o are registered and stable while out_valid_o=1 and out_ready_i=0.
  - fld_cnt_o reads NUM_FIELDS.
  - Handshake (out_valid_o & out_ready_i): next edge out_valid_o=0, cnt=0, state=IDLE. No field is accepted in the handshake cycle (one-cycle bubble by design).
- out_valid_o never drops without a handshake, except on abort or reset.
- abort_i (sync) from any state:
  - Next edge: IDLE, cnt=0, out_valid_o=0, shift register=0, out_word_o=0.
  - Takes priority over a simultaneous field accept and over a simultaneous output handshake; that field or word is discarded.
- Reset asserted mid-word or mid-HOLD: immediate return to the reset values; the partial or pending word is lost.
- fld_cnt_o never exceeds NUM_FIELDS; there is no wrap.

Decomposition:
- Shared package concat_pkg:
  - FIELD_W, NUM_FIELDS, REP, WORD_W, OUT_W constants.
  - State enum type seq_state_t {IDLE, COLLECT, HOLD}.
  - MODE_CONCAT=0, MODE_REP=1.
- One natural sub-module, field_shift_reg: parameterised FIELD_W x NUM_FIELDS left-shift register with load/shift/clear. The FSM, counter and output formatting stay in the top.

Test Plan:
- Concat: mode_i=0, fields 1,2,3,0,1 on consecutive cycles, out_ready_i=1 -> out_valid_o high 1 cycle after 5th accept, out_word_o=30'h00001B1, out_mode_o=0; IDLE next cycle.
- Replicate: mode_i=1 on first field only (then toggled to 0), same fields -> out_word_o=30'h1B16C5B1, out_mode_o=1.
- Backpressure: complete a word, hold out_ready_i=0 for 4 cycles with fld_valid_i=1 -> out_word_o stable, fld_ready_o=0, fld_cnt_o=5; raise out_ready_i -> one handshake, out_valid_o=0 next cycle.
- Gapped input: fields 3,_,3,_,_,3,3,3 (underscore = fld_valid_i low) -> fld_cnt_o steps 1..5 only on accepts; out_word_o=30'h00003FF.
- Abort: 3 fields accepted then abort_i=1 together with fld_valid_i=1 -> IDLE, fld_cnt_o=0, that field dropped; next 5 fields 2,2,2,2,2 -> 30'h00002AA. Abort during HOLD together with out_ready_i=1 -> no word delivered.
- Async reset: assert rst_n=0 mid-COLLECT between clock edges -> outputs zero immediately; after release, a fresh word assembles correctly.
